// File: rtl/conv3_window_feeder.sv
// Streams a 3x3 kernel and then every 3x3 window of a frame from memory into a
// 3x3 convolution unit, one 3-element row per push, and collects its results.
module conv3_window_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   img_base,
    input  logic [ADDR_WIDTH-1:0]   kern_base,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [3*DATA_WIDTH-1:0] conv_data_in,
    output logic                    conv_kernel_load,
    output logic                    conv_valid_in,
    output logic                    conv_valid_out,
    input  logic [DATA_WIDTH-1:0]   conv_result,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_valid,
    output logic                    res_last,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 3);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 3);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_K, S_FEED, S_DRAIN} state_t;
    state_t state_q, state_d;

    logic                    issuing_q, issuing_d;
    logic [1:0]              iss_i_q, iss_i_d, iss_j_q, iss_j_d;
    logic [RW-1:0]           win_r_q, win_r_d;
    logic [CW-1:0]           win_c_q, win_c_d;
    logic [ADDR_WIDTH-1:0]   img_base_q, img_base_d, kern_base_q, kern_base_d;
    logic                    mem_en_q, mem_en_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]              a_i_q, a_i_d, a_j_q, a_j_d, b_i_q, b_i_d, b_j_q, b_j_d;
    logic                    a_k_q, a_k_d, a_lw_q, a_lw_d;
    logic                    b_v_q, b_v_d, b_k_q, b_k_d, b_lw_q, b_lw_d;
    logic [DATA_WIDTH-1:0]   p0_q, p0_d, p1_q, p1_d;
    logic                    push_v_q, push_v_d, push_k_q, push_k_d;
    logic                    push_last_q, push_last_d, push_lw_q, push_lw_d;
    logic [3*DATA_WIDTH-1:0] push_data_q, push_data_d;
    logic                    vo1_q, vo1_d, vo1_lw_q, vo1_lw_d, vo_q, vo_d, vo_lw_q, vo_lw_d;
    logic                    rv_q, rv_d, rl_q, rl_d, done_q, done_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    issue, k_done, f_done;
    logic [31:0]             pix_off;

    // Row pushes come from a registered stage so the third kernel/window row is a clean event.
    assign k_done = push_v_q & push_k_q & push_last_q;
    assign f_done = push_v_q & ~push_k_q & push_last_q & push_lw_q;
    assign issue  = issuing_q & ((state_q == S_LOAD_K) | (state_q == S_FEED));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            issuing_q <= 1'b0; iss_i_q <= '0; iss_j_q <= '0; win_r_q <= '0; win_c_q <= '0;
            img_base_q <= '0; kern_base_q <= '0; mem_en_q <= 1'b0; mem_addr_q <= '0;
            a_i_q <= '0; a_j_q <= '0; a_k_q <= 1'b0; a_lw_q <= 1'b0;
            b_v_q <= 1'b0; b_i_q <= '0; b_j_q <= '0; b_k_q <= 1'b0; b_lw_q <= 1'b0;
            p0_q <= '0; p1_q <= '0; push_v_q <= 1'b0; push_k_q <= 1'b0;
            push_last_q <= 1'b0; push_lw_q <= 1'b0; push_data_q <= '0;
            vo1_q <= 1'b0; vo1_lw_q <= 1'b0; vo_q <= 1'b0; vo_lw_q <= 1'b0;
            rv_q <= 1'b0; rl_q <= 1'b0; hold_q <= '0; done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            issuing_q <= issuing_d; iss_i_q <= iss_i_d; iss_j_q <= iss_j_d;
            win_r_q <= win_r_d; win_c_q <= win_c_d;
            img_base_q <= img_base_d; kern_base_q <= kern_base_d;
            mem_en_q <= mem_en_d; mem_addr_q <= mem_addr_d;
            a_i_q <= a_i_d; a_j_q <= a_j_d; a_k_q <= a_k_d; a_lw_q <= a_lw_d;
            b_v_q <= b_v_d; b_i_q <= b_i_d; b_j_q <= b_j_d; b_k_q <= b_k_d; b_lw_q <= b_lw_d;
            p0_q <= p0_d; p1_q <= p1_d; push_v_q <= push_v_d; push_k_q <= push_k_d;
            push_last_q <= push_last_d; push_lw_q <= push_lw_d; push_data_q <= push_data_d;
            vo1_q <= vo1_d; vo1_lw_q <= vo1_lw_d; vo_q <= vo_d; vo_lw_q <= vo_lw_d;
            rv_q <= rv_d; rl_q <= rl_d; hold_q <= hold_d; done_q <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start)           state_d = S_LOAD_K;
            S_LOAD_K: if (k_done)          state_d = S_FEED;
            S_FEED:   if (f_done)          state_d = S_DRAIN;
            S_DRAIN:  if (rv_q && rl_q)    state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issuing_d = issuing_q; iss_i_d = iss_i_q; iss_j_d = iss_j_q;
        win_r_d = win_r_q; win_c_d = win_c_q;
        img_base_d = img_base_q; kern_base_d = kern_base_q;
        mem_en_d = 1'b0; mem_addr_d = mem_addr_q;
        pix_off = (32'(win_r_q) + 32'(iss_i_q)) * 32'(IMG_W) + 32'(win_c_q) + 32'(iss_j_q);
        a_i_d = iss_i_q; a_j_d = iss_j_q; a_k_d = (state_q == S_LOAD_K);
        a_lw_d = (state_q == S_FEED) && (win_r_q == R_LAST) && (win_c_q == C_LAST);
        if (state_q == S_IDLE && start) begin
            img_base_d = img_base; kern_base_d = kern_base; issuing_d = 1'b1;
            iss_i_d = '0; iss_j_d = '0; win_r_d = '0; win_c_d = '0;
        end
        if (state_q == S_LOAD_K && k_done) begin
            issuing_d = 1'b1; iss_i_d = '0; iss_j_d = '0; win_r_d = '0; win_c_d = '0;
        end
        // Reads run back to back across windows; only the kernel phase and the last window stop them.
        if (issue) begin
            mem_en_d = 1'b1;
            mem_addr_d = (state_q == S_LOAD_K)
                ? kern_base_q + ADDR_WIDTH'(32'(iss_i_q) * 32'd3 + 32'(iss_j_q))
                : img_base_q + ADDR_WIDTH'(pix_off);
            if (iss_j_q == 2'd2) begin
                iss_j_d = '0;
                if (iss_i_q == 2'd2) begin
                    iss_i_d = '0;
                    if (state_q == S_LOAD_K || a_lw_d) begin
                        issuing_d = 1'b0;
                    end else if (win_c_q == C_LAST) begin
                        win_c_d = '0;
                        win_r_d = win_r_q + 1'b1;
                    end else begin
                        win_c_d = win_c_q + 1'b1;
                    end
                end else begin
                    iss_i_d = iss_i_q + 2'd1;
                end
            end else begin
                iss_j_d = iss_j_q + 2'd1;
            end
        end
        b_v_d = mem_en_q; b_i_d = a_i_q; b_j_d = a_j_q; b_k_d = a_k_q; b_lw_d = a_lw_q;
        p0_d = p0_q; p1_d = p1_q; push_data_d = push_data_q;
        push_v_d = 1'b0; push_k_d = 1'b0; push_last_d = 1'b0; push_lw_d = 1'b0;
        if (b_v_q) begin
            case (b_j_q)
                2'd0: p0_d = mem_rdata;
                2'd1: p1_d = mem_rdata;
                default: begin
                    push_v_d = 1'b1; push_k_d = b_k_q;
                    push_last_d = (b_i_q == 2'd2); push_lw_d = b_lw_q;
                    push_data_d = {mem_rdata, p1_q, p0_q};
                end
            endcase
        end
        vo1_d = push_v_q & ~push_k_q & push_last_q; vo1_lw_d = push_lw_q;
        vo_d = vo1_q; vo_lw_d = vo1_lw_q;
        rv_d = vo_q; rl_d = vo_q & vo_lw_q;
        hold_d = rv_q ? conv_result : hold_q;
        done_d = (state_q == S_DRAIN) && rv_q && rl_q;
    end

    always_comb begin
        busy             = (state_q != S_IDLE);
        dbg_state        = state_q;
        done             = done_q;
        mem_en           = mem_en_q;
        mem_addr         = mem_addr_q;
        conv_data_in     = push_data_q;
        conv_kernel_load = push_k_q;
        conv_valid_in    = push_v_q;
        conv_valid_out   = vo_q;
        res_valid        = rv_q;
        res_last         = rl_q;
        // conv_result is already registered by the convolution unit; pass it through on the result cycle.
        res_data         = rv_q ? conv_result : hold_q;
    end
endmodule

// File: doc/conv3_window_feeder.md
CONV3_WINDOW_FEEDER -- requirements
Module: conv3_window_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel/weight width (FP16).
REQ-002 SHALL have parameter IMG_W, default 28, image width in pixels, minimum 3.
REQ-003 SHALL have parameter IMG_H, default 28, image height in pixels, minimum 3.
REQ-004 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle request to process one frame.
REQ-008 SHALL have port img_base  input  ADDR_WIDTH  address of pixel (0,0), sampled on accepted start.
REQ-009 SHALL have port kern_base  input  ADDR_WIDTH  address of weight (0,0), sampled on accepted start.
REQ-010 SHALL have port mem_en  output  1  read strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_WIDTH  read address.
REQ-012 SHALL have port mem_rdata  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_en.
REQ-013 SHALL have port conv_data_in  output  3 x DATA_WIDTH  one 3-element row to the 3x3 convolution unit.
REQ-014 SHALL have port conv_kernel_load  output  1  row carries kernel weights.
REQ-015 SHALL have port conv_valid_in  output  1  row push strobe.
REQ-016 SHALL have port conv_valid_out  output  1  convolution output latch strobe.
REQ-017 SHALL have port conv_result  input  DATA_WIDTH  registered output of the convolution unit.
REQ-018 SHALL have port res_data  output  DATA_WIDTH  result pixel.
REQ-019 SHALL have port res_valid  output  1  res_data valid, one cycle per result.
REQ-020 SHALL have port res_last  output  1  high with the final res_valid of a frame.
REQ-021 SHALL have port busy  output  1  high from accepted start until done.
REQ-022 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-023 SHALL implement states IDLE, LOAD_K, FEED, DRAIN: IDLE->LOAD_K on start; LOAD_K->FEED after third kernel row push; FEED->DRAIN after third row push of last window; DRAIN->IDLE on cycle of final res_valid.
REQ-024 SHALL ignore start while busy is high.
REQ-025 SHALL read weight (i,j) from kern_base+3*i+j and pixel (r,c) from img_base+r*IMG_W+c, modulo 2^ADDR_WIDTH.
REQ-026 SHALL in LOAD_K issue 9 reads and push rows i=0,1,2 in order with conv_kernel_load=1, conv_valid_in=1, conv_data_in[j]=weight(i,j).
REQ-027 SHALL process windows (r,c), r in 0..IMG_H-3, c in 0..IMG_W-3, raster order, c fastest.
REQ-028 SHALL per window issue exactly 9 reads and push rows i=0,1,2 in order with conv_kernel_load=0, conv_data_in[j]=pixel(r+i,c+j).
REQ-029 SHALL assert conv_valid_in only on row pushes, one cycle each; conv_kernel_load SHALL be 0 on every cycle outside LOAD_K pushes.
REQ-030 SHALL, with N the cycle of a window's third row push, drive conv_valid_out=1 in cycle N+2 only for that window.
REQ-031 SHALL sample conv_result in cycle N+3 and present it on res_data with res_valid=1 in that cycle.
REQ-032 SHALL overlap reads of the next window with the N+1..N+3 sequence; sustained throughput SHALL be at least one window per 10 cycles.
REQ-033 SHALL keep res_data stable between res_valid pulses; mem_addr SHALL be don't-care when mem_en=0.
REQ-034 SHALL emit exactly (IMG_W-2)*(IMG_H-2) res_valid pulses per frame, res_last on the final one.
REQ-035 SHALL pulse done in the cycle after the final res_valid, busy falling in the same cycle.
REQ-036 SHALL, for IMG_W=3 and IMG_H=3, produce exactly one window and one result with res_last=1.
REQ-037 SHALL accept a start in the cycle done is high-or-later, with no idle gap requirement beyond that.

Reset
REQ-038 SHALL on rst force state IDLE and all outputs to 0: mem_en, mem_addr, conv_data_in, conv_kernel_load, conv_valid_in, conv_valid_out, res_data, res_valid, res_last, busy, done.
REQ-039 SHALL on rst mid-frame abandon the frame with no further reads, pushes, or results; rst SHALL take priority over simultaneous start.

Verification
REQ-040 SHALL cover: IMG_W=IMG_H=4, kernel all 0x3C00, image all 0x3C00, paired with the 3x3 convolution unit -> 4 results of 0x4880 (9.0), res_last on 4th, done one cycle later.
REQ-041 SHALL cover: IMG_W=IMG_H=3, kernel centre 0x3C00 rest 0x0000, pixel(1,1)=0x4500 -> single result 0x4500 with res_last=1.
REQ-042 SHALL cover: IMG_W=5, IMG_H=4, img_base=0x0100 -> read addresses of window (1,2) are 0x0107..0x0109, 0x010C..0x010E, 0x0111..0x0113; 6 results in raster order.
REQ-043 SHALL cover: start pulsed again while busy -> ignored, result count per frame unchanged.
REQ-044 SHALL cover: rst asserted after second result -> all outputs 0 next cycle, no further mem_en; subsequent start yields complete correct frame.
REQ-045 SHALL cover: conv_valid_in/conv_valid_out timing check -> conv_valid_out exactly 2 cycles after each third image push, 3 image pushes per window, 3 kernel pushes per frame.
